// File: rtl/lcd_seq_pkg.sv
// Shared state encoding, command bytes and sizing constants for the
// ST7735 sequencer and its init ROM.
package lcd_seq_pkg;

  typedef enum logic [6:0] {
    ST_RST_LOW  = 7'b000_0001,
    ST_RST_HIGH = 7'b000_0010,
    ST_SLPOUT   = 7'b000_0100,
    ST_WAIT_SLP = 7'b000_1000,
    ST_INIT     = 7'b001_0000,
    ST_FILL     = 7'b010_0000,
    ST_IDLE     = 7'b100_0000
  } state_e;

  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_MADCTL = 8'h36;
  localparam logic [7:0] CMD_COLMOD = 8'h3A;
  localparam logic [7:0] CMD_DISPON = 8'h29;

  localparam logic [8:0] DATA_IDLE = 9'h100;

  localparam int INIT_LEN     = 53;
  localparam int INIT_IW      = $clog2(INIT_LEN);
  localparam int MADCTL_SLOT  = 15;
  localparam int FILL_HDR_LEN = 11;

  function automatic logic [7:0] clamp8(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/st7735_init_rom.sv
// Init command table for ST7735 panels; the orientation byte is patched
// into the MADCTL data slot from the caller's latched value.
module st7735_init_rom
  import lcd_seq_pkg::*;
(
  input  logic [INIT_IW-1:0] idx,
  input  logic [7:0]         madctl,
  output logic [8:0]         word
);

  localparam logic [8:0] TAB [INIT_LEN] = '{
    9'h0B1, 9'h101, 9'h12C, 9'h12D,
    9'h0B4, 9'h107,
    9'h0C0, 9'h1A2, 9'h102, 9'h184,
    9'h0C1, 9'h1C5,
    9'h0C5, 9'h10E,
    {1'b0, CMD_MADCTL}, DATA_IDLE,
    {1'b0, CMD_COLMOD}, 9'h105,
    9'h0E0,
    9'h102, 9'h11C, 9'h107, 9'h112,
    9'h137, 9'h132, 9'h129, 9'h12D,
    9'h129, 9'h125, 9'h12B, 9'h139,
    9'h100, 9'h101, 9'h103, 9'h110,
    9'h0E1,
    9'h103, 9'h11D, 9'h107, 9'h106,
    9'h12E, 9'h12C, 9'h129, 9'h12D,
    9'h12E, 9'h12E, 9'h137, 9'h13F,
    9'h100, 9'h100, 9'h102, 9'h110,
    {1'b0, CMD_DISPON}
  };

  always_comb begin
    word = DATA_IDLE;
    if (idx == INIT_IW'(MADCTL_SLOT)) begin
      word = {1'b1, madctl};
    end else if (int'(idx) < INIT_LEN) begin
      word = TAB[idx];
    end
  end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// ST7735 sequencer: reset pulse, sleep-out, init table, auto clear,
// then runtime rectangle fills and re-init on request.
module lcd_seq_ctrl
  import lcd_seq_pkg::*;
#(
  parameter int          H_RES      = 128,
  parameter int          V_RES      = 160,
  parameter int          T_RST_LOW  = 1000000,
  parameter int          T_RST_HIGH = 1000000,
  parameter int          T_SLPOUT   = 250000,
  parameter logic [15:0] CLR_COLOR  = 16'h0010
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_done,
  input  logic        reinit,
  input  logic [7:0]  madctl,
  input  logic        fill_req,
  input  logic [7:0]  fill_x0,
  input  logic [7:0]  fill_x1,
  input  logic [7:0]  fill_y0,
  input  logic [7:0]  fill_y1,
  input  logic [15:0] fill_color,
  output logic        lcd_rst,
  output logic [8:0]  init_data,
  output logic        en_write,
  output logic        init_done,
  output logic        busy,
  output logic        fill_done
);

  localparam int         PW      = $clog2(H_RES * V_RES + 1);
  localparam logic [7:0] XMAX    = 8'(H_RES - 1);
  localparam logic [7:0] YMAX    = 8'(V_RES - 1);
  localparam logic [3:0] HDR_END = 4'(FILL_HDR_LEN);

  state_e             state_q, state_d;
  logic [31:0]        dly_q, dly_d;
  logic [INIT_IW-1:0] idx_q, idx_d;
  logic [3:0]         widx_q, widx_d;
  logic [PW-1:0]      pix_q, pix_d;
  logic               phase_q, phase_d;
  logic [7:0]         madctl_q, madctl_d;
  logic [7:0]         xa_q, xa_d, xb_q, xb_d;
  logic [7:0]         ya_q, ya_d, yb_q, yb_d;
  logic [15:0]        color_q, color_d;
  logic               fill_done_q, fill_done_d;

  logic [8:0]    rom_word, fill_word;
  logic [8:0]    wx, wy;
  logic [PW-1:0] npix;
  logic [7:0]    xlo, xhi, ylo, yhi;

  st7735_init_rom u_rom (
    .idx    (idx_q),
    .madctl (madctl_q),
    .word   (rom_word)
  );

  assign wx   = {1'b0, xb_q} - {1'b0, xa_q} + 9'd1;
  assign wy   = {1'b0, yb_q} - {1'b0, ya_q} + 9'd1;
  assign npix = PW'(wx) * PW'(wy);

  assign xlo = (fill_x0 > fill_x1) ? fill_x1 : fill_x0;
  assign xhi = (fill_x0 > fill_x1) ? fill_x0 : fill_x1;
  assign ylo = (fill_y0 > fill_y1) ? fill_y1 : fill_y0;
  assign yhi = (fill_y0 > fill_y1) ? fill_y0 : fill_y1;

  assign lcd_rst   = (state_q != ST_RST_LOW);
  assign init_done = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign fill_done = fill_done_q;

  // Window header slots 1,3,6,8 are the 0x00 high bytes, i.e. DATA_IDLE
  always_comb begin
    fill_word = DATA_IDLE;
    case (widx_q)
      4'd0:    fill_word = {1'b0, CMD_CASET};
      4'd2:    fill_word = {1'b1, xa_q};
      4'd4:    fill_word = {1'b1, xb_q};
      4'd5:    fill_word = {1'b0, CMD_RASET};
      4'd7:    fill_word = {1'b1, ya_q};
      4'd9:    fill_word = {1'b1, yb_q};
      4'd10:   fill_word = {1'b0, CMD_RAMWR};
      4'd11:   fill_word = {1'b1, phase_q ? color_q[7:0] : color_q[15:8]};
      default: fill_word = DATA_IDLE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    idx_d       = idx_q;
    widx_d      = widx_q;
    pix_d       = pix_q;
    phase_d     = phase_q;
    madctl_d    = madctl_q;
    xa_d        = xa_q;
    xb_d        = xb_q;
    ya_d        = ya_q;
    yb_d        = yb_q;
    color_d     = color_q;
    fill_done_d = 1'b0;
    en_write    = 1'b0;
    init_data   = DATA_IDLE;
    unique case (state_q)
      ST_RST_LOW: begin
        dly_d = dly_q + 32'd1;
        if (dly_q == 32'(T_RST_LOW - 1)) begin
          state_d = ST_RST_HIGH;
          dly_d   = '0;
        end
      end
      ST_RST_HIGH: begin
        dly_d = dly_q + 32'd1;
        if (dly_q == 32'(T_RST_HIGH - 1)) begin
          state_d = ST_SLPOUT;
          dly_d   = '0;
        end
      end
      ST_SLPOUT: begin
        en_write  = 1'b1;
        init_data = {1'b0, CMD_SLPOUT};
        if (wr_done) begin
          state_d = ST_WAIT_SLP;
          dly_d   = '0;
        end
      end
      ST_WAIT_SLP: begin
        dly_d = dly_q + 32'd1;
        if (dly_q == 32'(T_SLPOUT - 1)) begin
          state_d  = ST_INIT;
          dly_d    = '0;
          idx_d    = '0;
          madctl_d = madctl;
        end
      end
      ST_INIT: begin
        en_write  = 1'b1;
        init_data = rom_word;
        if (wr_done) begin
          idx_d = idx_q + INIT_IW'(1);
          if (idx_q == INIT_IW'(INIT_LEN - 1)) begin
            state_d = ST_FILL;
            idx_d   = '0;
            widx_d  = '0;
            pix_d   = '0;
            phase_d = 1'b0;
            xa_d    = 8'd0;
            xb_d    = XMAX;
            ya_d    = 8'd0;
            yb_d    = YMAX;
            color_d = CLR_COLOR;
          end
        end
      end
      ST_FILL: begin
        en_write  = 1'b1;
        init_data = fill_word;
        if (wr_done) begin
          if (widx_q != HDR_END) begin
            widx_d = widx_q + 4'd1;
          end else if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            pix_d   = pix_q + PW'(1);
            if (pix_q == npix - PW'(1)) begin
              state_d     = ST_IDLE;
              fill_done_d = 1'b1;
              pix_d       = '0;
              widx_d      = '0;
            end
          end
        end
      end
      ST_IDLE: begin
        if (fill_req) begin
          state_d = ST_FILL;
          widx_d  = '0;
          pix_d   = '0;
          phase_d = 1'b0;
          xa_d    = clamp8(xlo, XMAX);
          xb_d    = clamp8(xhi, XMAX);
          ya_d    = clamp8(ylo, YMAX);
          yb_d    = clamp8(yhi, YMAX);
          color_d = fill_color;
        end
      end
      default: state_d = ST_RST_LOW;
    endcase
    // Re-init overrides whatever the current state decided
    if (reinit) begin
      state_d     = ST_RST_LOW;
      dly_d       = '0;
      idx_d       = '0;
      widx_d      = '0;
      pix_d       = '0;
      phase_d     = 1'b0;
      fill_done_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_RST_LOW;
      dly_q       <= '0;
      idx_q       <= '0;
      widx_q      <= '0;
      pix_q       <= '0;
      phase_q     <= 1'b0;
      madctl_q    <= '0;
      xa_q        <= '0;
      xb_q        <= '0;
      ya_q        <= '0;
      yb_q        <= '0;
      color_q     <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      widx_q      <= widx_d;
      pix_q       <= pix_d;
      phase_q     <= phase_d;
      madctl_q    <= madctl_d;
      xa_q        <= xa_d;
      xb_q        <= xb_d;
      ya_q        <= ya_d;
      yb_q        <= yb_d;
      color_q     <= color_d;
      fill_done_q <= fill_done_d;
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl on a tiny 4x3 panel with short delays
// and a writer that acknowledges each word a few cycles after it appears.
module tb_lcd_seq_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        reinit = 1'b0;
  logic        fill_req = 1'b0;
  logic [7:0]  madctl = 8'hC0;
  logic [7:0]  fill_x0 = 8'd0;
  logic [7:0]  fill_x1 = 8'd0;
  logic [7:0]  fill_y0 = 8'd0;
  logic [7:0]  fill_y1 = 8'd0;
  logic [15:0] fill_color = 16'h0000;
  logic        wr_w = 1'b0;
  logic        spur = 1'b0;
  logic        wr_done;
  logic        lcd_rst, en_write, init_done, busy, fill_done;
  logic [8:0]  init_data;

  int          checks = 0;
  int          errors = 0;
  int          fd = 0;
  int          wcnt = 0;
  logic [8:0]  held = 9'h000;
  logic [8:0]  words[$];
  logic [8:0]  exp_q[$];

  logic [8:0] init_tab [53] = '{
    9'h0B1, 9'h101, 9'h12C, 9'h12D, 9'h0B4, 9'h107,
    9'h0C0, 9'h1A2, 9'h102, 9'h184, 9'h0C1, 9'h1C5,
    9'h0C5, 9'h10E, 9'h036, 9'h1C0, 9'h03A, 9'h105,
    9'h0E0,
    9'h102, 9'h11C, 9'h107, 9'h112, 9'h137, 9'h132, 9'h129, 9'h12D,
    9'h129, 9'h125, 9'h12B, 9'h139, 9'h100, 9'h101, 9'h103, 9'h110,
    9'h0E1,
    9'h103, 9'h11D, 9'h107, 9'h106, 9'h12E, 9'h12C, 9'h129, 9'h12D,
    9'h12E, 9'h12E, 9'h137, 9'h13F, 9'h100, 9'h100, 9'h102, 9'h110,
    9'h029
  };

  assign wr_done = wr_w | spur;

  always #5 sys_clk = ~sys_clk;

  lcd_seq_ctrl #(
    .H_RES      (4),
    .V_RES      (3),
    .T_RST_LOW  (10),
    .T_RST_HIGH (10),
    .T_SLPOUT   (5),
    .CLR_COLOR  (16'h0010)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .wr_done    (wr_done),
    .reinit     (reinit),
    .madctl     (madctl),
    .fill_req   (fill_req),
    .fill_x0    (fill_x0),
    .fill_x1    (fill_x1),
    .fill_y0    (fill_y0),
    .fill_y1    (fill_y1),
    .fill_color (fill_color),
    .lcd_rst    (lcd_rst),
    .init_data  (init_data),
    .en_write   (en_write),
    .init_done  (init_done),
    .busy       (busy),
    .fill_done  (fill_done)
  );

  // Writer model: acks the third cycle a word is held, logs accepted words
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_w = 1'b0;
      wcnt = 0;
    end else if (wr_w) begin
      wr_w = 1'b0;
      wcnt = 0;
    end else if (en_write === 1'b1) begin
      if (wcnt > 0) begin
        checks++;
        if (init_data !== held) begin
          errors++;
          $display("FAIL word_stable: got %h want %h", init_data, held);
        end
      end
      held = init_data;
      wcnt++;
      if (wcnt == 3) begin
        words.push_back(init_data);
        wr_w = 1'b1;
      end
    end else begin
      wcnt = 0;
    end
    if (fill_done === 1'b1) fd++;
  end

  task automatic push_init();
    exp_q.push_back(9'h011);
    for (int i = 0; i < 53; i++) exp_q.push_back(init_tab[i]);
  endtask

  task automatic push_win(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] ya, input logic [7:0] yb);
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, xa});
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, xb});
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, ya});
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, yb});
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_pix(input int n, input logic [15:0] c);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < 5000) begin
      n++;
      @(negedge sys_clk);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: init_done=%b want 1", tag, init_done);
    end
  endtask

  task automatic measure_seq(input bit spur_slp);
    int n;
    n = 0;
    while (lcd_rst === 1'b0 && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL rst_low_cycles: got %0d want 10", n);
    end
    n = 0;
    while (en_write !== 1'b1 && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL rst_high_cycles: got %0d want 10", n);
    end
    checks++;
    if (init_data !== 9'h011) begin
      errors++;
      $display("FAIL slpout_word: got %h want 011", init_data);
    end
    n = 0;
    while (en_write === 1'b1 && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    n = 0;
    while (en_write !== 1'b1 && n < 100) begin
      spur = spur_slp && (n == 1);
      n++;
      @(negedge sys_clk);
    end
    spur = 1'b0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL slpout_gap: got %0d want 5", n);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (lcd_rst !== 1'b0 || init_data !== 9'h100 || en_write !== 1'b0 ||
        init_done !== 1'b0 || busy !== 1'b1 || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rst=%b data=%h en=%b done=%b busy=%b fd=%b want 0 100 0 0 1 0",
               lcd_rst, init_data, en_write, init_done, busy, fill_done);
    end
  endtask

  task automatic test_powerup();
    int n = 0;
    words.delete();
    fd = 0;
    sys_rst_n = 1'b1;
    measure_seq(1'b0);
    while (words.size() < 54 && n < 1000) begin
      n++;
      @(negedge sys_clk);
    end
    exp_q.delete();
    push_init();
    checks++;
    if (words.size() < 54) begin
      errors++;
      $display("FAIL init_len: got %0d want >=54", words.size());
    end
    for (int i = 0; i < 54 && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL init_word[%0d]: got %h want %h", i, words[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fill_req_busy();
    int n = 0;
    while (words.size() < 58 && n < 1000) begin
      n++;
      @(negedge sys_clk);
    end
    fill_x0 = 8'd1;
    fill_x1 = 8'd1;
    fill_y0 = 8'd1;
    fill_y1 = 8'd1;
    fill_color = 16'hFFFF;
    fill_req = 1'b1;
    @(negedge sys_clk);
    fill_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_during_clear: got %b want 1", busy);
    end
    wait_idle("clear");
  endtask

  task automatic test_auto_clear();
    int sz;
    exp_q.delete();
    push_init();
    push_win(8'd0, 8'd3, 8'd0, 8'd2);
    push_pix(12, 16'h0010);
    checks++;
    if (fill_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle_entry: got fd=%b busy=%b want 1 0", fill_done, busy);
    end
    @(negedge sys_clk);
    checks++;
    if (words.size() != exp_q.size()) begin
      errors++;
      $display("FAIL clear_len: got %0d want %0d", words.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL clear_word[%0d]: got %h want %h", i, words[i], exp_q[i]);
      end
    end
    sz = words.size();
    repeat (10) @(negedge sys_clk);
    checks++;
    if (fd != 1 || fill_done !== 1'b0 || init_done !== 1'b1 || words.size() != sz) begin
      errors++;
      $display("FAIL clear_done: got pulses=%0d fd=%b done=%b words=%0d want 1 0 1 %0d",
               fd, fill_done, init_done, words.size(), sz);
    end
  endtask

  task automatic test_fill();
    words.delete();
    fd = 0;
    fill_x0 = 8'd2;
    fill_x1 = 8'd1;
    fill_y0 = 8'd0;
    fill_y1 = 8'd5;
    fill_color = 16'hF800;
    fill_req = 1'b1;
    @(negedge sys_clk);
    fill_req = 1'b0;
    checks++;
    if (en_write !== 1'b1 || init_data !== 9'h02A || busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_latency: got en=%b data=%h busy=%b want 1 02a 1",
               en_write, init_data, busy);
    end
    wait_idle("fill");
    @(negedge sys_clk);
    exp_q.delete();
    push_win(8'd1, 8'd2, 8'd0, 8'd2);
    push_pix(6, 16'hF800);
    checks++;
    if (words.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fill_len: got %0d want %0d", words.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fill_word[%0d]: got %h want %h", i, words[i], exp_q[i]);
      end
    end
    checks++;
    if (fd != 1) begin
      errors++;
      $display("FAIL fill_done_count: got %0d want 1", fd);
    end
  endtask

  task automatic test_spurious_idle();
    words.delete();
    fd = 0;
    spur = 1'b1;
    @(negedge sys_clk);
    spur = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0 || en_write !== 1'b0 || words.size() != 0) begin
      errors++;
      $display("FAIL spur_idle: got done=%b busy=%b en=%b words=%0d want 1 0 0 0",
               init_done, busy, en_write, words.size());
    end
    fill_x0 = 8'd9;
    fill_x1 = 8'd7;
    fill_y0 = 8'd1;
    fill_y1 = 8'd1;
    fill_color = 16'h1234;
    fill_req = 1'b1;
    @(negedge sys_clk);
    fill_req = 1'b0;
    wait_idle("pixel");
    @(negedge sys_clk);
    exp_q.delete();
    push_win(8'd3, 8'd3, 8'd1, 8'd1);
    push_pix(1, 16'h1234);
    checks++;
    if (words.size() != exp_q.size()) begin
      errors++;
      $display("FAIL pixel_len: got %0d want %0d", words.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pixel_word[%0d]: got %h want %h", i, words[i], exp_q[i]);
      end
    end
    checks++;
    if (fd != 1) begin
      errors++;
      $display("FAIL pixel_done_count: got %0d want 1", fd);
    end
  endtask

  task automatic test_reinit();
    int n = 0;
    words.delete();
    fd = 0;
    fill_x0 = 8'd0;
    fill_x1 = 8'd3;
    fill_y0 = 8'd0;
    fill_y1 = 8'd2;
    fill_color = 16'hABCD;
    fill_req = 1'b1;
    @(negedge sys_clk);
    fill_req = 1'b0;
    while (words.size() < 15 && n < 1000) begin
      n++;
      @(negedge sys_clk);
    end
    reinit = 1'b1;
    fill_req = 1'b1;
    @(negedge sys_clk);
    reinit = 1'b0;
    fill_req = 1'b0;
    checks++;
    if (lcd_rst !== 1'b0 || en_write !== 1'b0 || init_done !== 1'b0 ||
        busy !== 1'b1 || fill_done !== 1'b0 || fd != 0) begin
      errors++;
      $display("FAIL reinit_next: got rst=%b en=%b done=%b busy=%b fd=%b n=%0d want 0 0 0 1 0 0",
               lcd_rst, en_write, init_done, busy, fill_done, fd);
    end
    words.delete();
    measure_seq(1'b1);
    wait_idle("replay");
    @(negedge sys_clk);
    exp_q.delete();
    push_init();
    push_win(8'd0, 8'd3, 8'd0, 8'd2);
    push_pix(12, 16'h0010);
    checks++;
    if (words.size() != exp_q.size()) begin
      errors++;
      $display("FAIL replay_len: got %0d want %0d", words.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < words.size(); i++) begin
      checks++;
      if (words[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL replay_word[%0d]: got %h want %h", i, words[i], exp_q[i]);
      end
    end
    checks++;
    if (fd != 1) begin
      errors++;
      $display("FAIL replay_done_count: got %0d want 1", fd);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    test_reset();
    test_powerup();
    test_fill_req_busy();
    test_auto_clear();
    test_fill();
    test_spurious_idle();
    test_reinit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_seq_ctrl.md
Name: lcd_seq_ctrl

Overview:
Parametrised ST7735-class SPI-LCD sequencer. Generates the reset pulse, sleep-out and init command stream, and an automatic full-screen clear, then stays available for runtime rectangular colour fills and full re-initialisation.
Emits 9-bit words {dc, byte} to the downstream SPI byte writer using an en_write/wr_done handshake.
Adds over the previous init block: runtime fill windows, runtime colour and orientation, re-init without a global reset, and generic panel size.

Parameters:
H_RES, 128, panel columns (1..256)
V_RES, 160, panel rows (1..256)
T_RST_LOW, 1000000, cycles lcd_rst held low after reset/reinit
T_RST_HIGH, 1000000, cycles after lcd_rst rises before sleep-out
T_SLPOUT, 250000, cycles after 0x11 accepted before init table
CLR_COLOR, 16'h0010, RGB565 colour of the post-init clear

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset
wr_done  in  1  one-cycle pulse: current word consumed by the writer
reinit  in  1  one-cycle pulse: restart the full sequence
madctl  in  8  orientation byte, sampled when the init table starts
fill_req  in  1  one-cycle request for a rectangle fill
fill_x0, fill_x1  in  8 each  column bounds
fill_y0, fill_y1  in  8 each  row bounds
fill_color  in  16  RGB565 fill colour
lcd_rst  out  1  panel reset, active low
init_data  out  9  [8]=1 data, [8]=0 command; [7:0]=byte
en_write  out  1  init_data is valid and must be sent
init_done  out  1  high in IDLE only
busy  out  1  state != IDLE
fill_done  out  1  one-cycle pulse when a fill (including the clear) ends

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk. State RST_LOW, all counters 0.
- Output reset values: lcd_rst=0, init_data=9'h100, en_write=0, init_done=0, busy=1, fill_done=0.

States and transitions:
- RST_LOW: count T_RST_LOW cycles, then go to RST_HIGH; lcd_rst rises on that transition edge and stays 1.
- RST_HIGH: count T_RST_HIGH cycles, then go to SLPOUT.
- SLPOUT: present 9'h011, then go to WAIT_SLP on wr_done.
- WAIT_SLP: count T_SLPOUT cycles, then go to INIT.
- INIT: stream INIT_LEN table words from ROM; the MADCTL data word is the madctl value latched on INIT entry. After the last wr_done, load the window 0,0..H_RES-1,V_RES-1 with CLR_COLOR, then go to FILL.
- FILL: stream the fill sequence, then go to IDLE; fill_done pulses on the IDLE-entry cycle.
- IDLE: fill_req latches coords and colour, then go to FILL.

Write handshake:
- en_write=1 in SLPOUT, INIT and FILL only.
- init_data is stable while en_write=1 until wr_done.
- On wr_done the index advances; the next word is valid on the following cycle.
- wr_done while en_write=0 is ignored.
- When en_write=0, init_data=9'h100.

Fill sequence:
- Words in order: 0_2A, 1_00, 1_xa, 1_00, 1_xb, 0_2B, 1_00, 1_ya, 1_00, 1_yb, 0_2C.
- Then N pixels as colour[15:8] followed by colour[7:0].
- N=(xb-xa+1)*(yb-ya+1). Pixel counter width is clog2(H_RES*V_RES+1), and the byte phase is a separate toggle bit.

Coordinate normalisation (at latch):
- If x0>x1, swap them; likewise for y.
- Clamp each bound to H_RES-1 / V_RES-1.
- Degenerate single-pixel windows are legal: N=1, 2 colour bytes.

Latency and request rules:
- fill_req accepted on cycle n gives en_write=1 with 0_2A on cycle n+1.
- fill_req outside IDLE is dropped, with no queueing.
- fill_req and reinit in the same cycle: reinit wins.
- reinit in any state (including mid-fill or mid-word): next state RST_LOW, lcd_rst=0 next cycle, en_write=0, all counters cleared, no fill_done.

Decomposition:
- Package lcd_seq_pkg: state encoding (one-hot), command constants (SLPOUT 0x11, CASET 0x2A, RASET 0x2B, RAMWR 0x2C, MADCTL 0x36, COLMOD 0x3A, DISPON 0x29), DATA_IDLE=9'h100, INIT_LEN.
- Sub-module st7735_init_rom: combinational index-to-9-bit word ROM (frame rate, power, VCOM, gamma, COLMOD=05, DISPON), with a madctl input patched in at the MADCTL data slot.

Test Plan (T_RST_LOW=10, T_RST_HIGH=10, T_SLPOUT=5, H_RES=4, V_RES=3, writer model acks 3 cycles after en_write):
1. Power-up: lcd_rst low for 10 cycles then high; 10 cycles later init_data=0_11; after ack, 5 idle cycles; then the INIT_LEN table with madctl=8'hC0 at the MADCTL slot.
2. Auto clear: 11 window words (xb=03, yb=02), then 24 data bytes alternating 1_00/1_10; then fill_done pulses once, init_done=1, busy=0.
3. Fill request x0=2, x1=1, y0=0, y1=5, color=F800 in IDLE: en_write the next cycle with 0_2A; window 1..2 x 0..2; 12 bytes F8,00 repeated; fill_done once.
4. fill_req while busy during the clear: ignored; the word stream is unchanged and no extra fill_done occurs.
5. reinit asserted mid-pixel-stream: next cycle lcd_rst=0, en_write=0, init_done=0; the full sequence replays and no fill_done is emitted for the aborted fill.
6. Spurious wr_done in WAIT_SLP and IDLE: no index advance and no state change.
